// File: rtl/isa_pkg.sv
// Shared ISA definitions: op mnemonics, opcode prefixes, ALU and flag codes.
// Pure definitions, no timing.
// Used by the instruction loader and the control decoder alike.
package isa_pkg;

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_B   = 4'd1,
        OP_LI  = 4'd2,
        OP_LSL = 4'd3,
        OP_LSR = 4'd4,
        OP_LB  = 4'd5,
        OP_SB  = 4'd6,
        OP_SBF = 4'd7,
        OP_ADD = 4'd8,
        OP_SUB = 4'd9,
        OP_AND = 4'd10,
        OP_OR  = 4'd11,
        OP_NOT = 4'd12,
        OP_XOR = 4'd13
    } op_e;

    // Opcode prefixes (msbs of the 9-bit word)
    localparam logic [2:0] PFX_B   = 3'b100;
    localparam logic [2:0] PFX_LI  = 3'b101;
    localparam logic [2:0] PFX_SH  = 3'b110;
    localparam logic [3:0] PFX_ALU = 4'b1110;
    localparam logic [3:0] PFX_MEM = 4'b1111;

    // ALU sub-opcodes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_NOT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    // SBF shares the ALU prefix; selector 11 sits above the used op3 range
    localparam logic [1:0] SBF_SEL = 2'b11;

    // Flag codes accepted by SBF
    localparam logic [2:0] FLAG_A = 3'b001;
    localparam logic [2:0] FLAG_B = 3'b011;

    function automatic logic [2:0] alu_op3(input op_e op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_NOT:  return ALU_NOT;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instr_enc.sv
// Instruction encoder: op + fields -> 9-bit word plus legality flag.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is consumed.
module instr_enc
    import isa_pkg::*;
(
    input  op_e        op,
    input  logic [3:0] rd,
    input  logic [3:0] rs,
    input  logic [5:0] imm,
    output logic [8:0] word,
    output logic       legal
);

    // Build the word and check the field constraints for each op class
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (op)
            OP_MOV: begin
                word  = {1'b0, rd, rs};
                legal = ~rs[0];
            end
            OP_B: begin
                word  = {PFX_B, imm};
                legal = imm[0];
            end
            OP_LI: begin
                word  = {PFX_LI, imm};
                legal = imm[0];
            end
            OP_LSL, OP_LSR: begin
                word  = {PFX_SH, (op == OP_LSR), rd[1:0], imm[2:0]};
                legal = (rd[3:2] == 2'b00) && imm[0];
            end
            OP_LB, OP_SB: begin
                word  = {PFX_MEM, ((op == OP_SB) ? 2'b01 : 2'b00), rs[2:0]};
                legal = ~rs[3] & rs[0];
            end
            OP_SBF: begin
                word  = {PFX_ALU, SBF_SEL, imm[2:0]};
                legal = (imm[2:0] == FLAG_A) || (imm[2:0] == FLAG_B);
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR: begin
                word  = {PFX_ALU, alu_op3(op), rd[1:0]};
                legal = (rd[3:2] == 2'b00) && rd[0];
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a session of instruction beats into instruction memory, one word per beat.
// Latency 1: a beat accepted at edge N is written in the cycle after edge N.
// in_ready only while loading; one beat per cycle, errors stall until a new Start.
module instr_loader
    import isa_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] BaseAddr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [3:0]    in_rd,
    input  logic [3:0]    in_rs,
    input  logic [5:0]    in_imm,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [8:0]    imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [AW-1:0] err_addr,
    output logic [AW:0]   count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    logic [2:0]  state;
    // One extra bit: set once the top address has been written
    logic [AW:0] addr_cnt;
    logic [8:0]  enc_word;
    logic        enc_legal;
    logic        accept;
    logic        start_ok;

    instr_enc u_enc (
        .op    (op_e'(in_op)),
        .rd    (in_rd),
        .rs    (in_rs),
        .imm   (in_imm),
        .word  (enc_word),
        .legal (enc_legal)
    );

    assign in_ready = (state == S_LOAD);
    assign busy     = (state == S_LOAD) || (state == S_FLUSH);
    assign done     = (state == S_DONE);
    assign accept   = in_valid & in_ready;
    assign start_ok = Start && ((state == S_IDLE) || (state == S_ERROR));

    // Session FSM, address/count tracking, error capture and the output write register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= S_IDLE;
            addr_cnt   <= '0;
            count      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            err_addr   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start_ok) begin
                state    <= S_LOAD;
                addr_cnt <= {1'b0, BaseAddr};
                count    <= '0;
                err      <= 1'b0;
                err_code <= 2'b00;
                err_addr <= '0;
            end else begin
                case (state)
                    S_LOAD: begin
                        if (accept) begin
                            if (addr_cnt[AW]) begin
                                state    <= S_ERROR;
                                err      <= 1'b1;
                                err_code <= ERR_OVERFLOW;
                                err_addr <= addr_cnt[AW-1:0];
                            end else if (!enc_legal) begin
                                state    <= S_ERROR;
                                err      <= 1'b1;
                                err_code <= ERR_ILLEGAL;
                                err_addr <= addr_cnt[AW-1:0];
                            end else begin
                                imem_we    <= 1'b1;
                                imem_addr  <= addr_cnt[AW-1:0];
                                imem_wdata <= enc_word;
                                addr_cnt   <= addr_cnt + (AW+1)'(1);
                                count      <= count + (AW+1)'(1);
                                if (in_last) begin
                                    state <= S_FLUSH;
                                end
                            end
                        end
                    end
                    // The final word is on the write port this cycle and drains at this edge
                    S_FLUSH: state <= S_DONE;
                    S_DONE:  state <= S_IDLE;
                    S_IDLE, S_ERROR: state <= state;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed cases plus randomized sessions.
// Expected words come from an arithmetic reference encoder; addresses from a simple model.
// Inputs driven 1 time unit after the rising edge, outputs checked at the same point.
module tb_instr_loader;

    localparam int AW  = 8;
    localparam int TOP = (1 << AW);

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          Start = 1'b0;
    logic [AW-1:0] BaseAddr = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [3:0]    in_rd = '0;
    logic [3:0]    in_rs = '0;
    logic [5:0]    in_imm = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [8:0]    imem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW-1:0] err_addr;
    logic [AW:0]   count;

    int total = 0;
    int bad   = 0;
    int m_addr;
    int m_count;
    int m_code;

    instr_loader #(.AW(AW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .BaseAddr   (BaseAddr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .err_addr   (err_addr),
        .count      (count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference encoder: word as a plain number, ops numbered in mnemonic order MOV..XOR
    function automatic void ref_enc(input int op, input int rd, input int rs, input int imm,
                                    output int word, output bit legal);
        case (op)
            0: begin word = rd * 16 + rs; legal = (rs % 2 == 0); end
            1: begin word = 256 + imm; legal = (imm % 2 == 1); end
            2: begin word = 320 + imm; legal = (imm % 2 == 1); end
            3, 4: begin
                word  = 384 + (op - 3) * 32 + (rd % 4) * 8 + (imm % 8);
                legal = (rd < 4) && (imm % 2 == 1);
            end
            5, 6: begin
                word  = 480 + (op - 5) * 8 + (rs % 8);
                legal = (rs < 8) && (rs % 2 == 1);
            end
            7: begin
                word  = 448 + 24 + (imm % 8);
                legal = ((imm % 8) == 1) || ((imm % 8) == 3);
            end
            8, 9, 10, 11, 12, 13: begin
                word  = 448 + (op - 8) * 4 + (rd % 4);
                legal = (rd < 4) && (rd % 2 == 1);
            end
            default: begin word = 0; legal = 1'b0; end
        endcase
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_code"}, err_code, 0);
        chk({tag, "_eaddr"}, err_addr, 0);
        chk({tag, "_count"}, count, 0);
    endtask

    task automatic do_start(input int base);
        BaseAddr = base[AW-1:0];
        Start    = 1'b1;
        step();
        Start    = 1'b0;
        m_addr   = base;
        m_count  = 0;
        chk("start_ready", in_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_err", err, 0);
        chk("start_count", count, 0);
        chk("start_we", imem_we, 0);
    endtask

    // Idle cycles inside a session; optionally pulse Start, which must be ignored
    task automatic idle(input int n, input bit ghost);
        for (int i = 0; i < n; i++) begin
            if (ghost && i == 0) begin
                Start    = 1'b1;
                BaseAddr = AW'($urandom_range(0, TOP - 1));
            end
            step();
            Start = 1'b0;
            chk("idle_we", imem_we, 0);
            chk("idle_ready", in_ready, 1);
            chk("idle_count", count, m_count);
        end
    endtask

    task automatic do_beat(input int op, input int rd, input int rs, input int imm,
                           input bit last, output bit ok);
        int  word;
        bit  legal;
        ref_enc(op, rd, rs, imm, word, legal);
        in_valid = 1'b1;
        in_op    = op[3:0];
        in_rd    = rd[3:0];
        in_rs    = rs[3:0];
        in_imm   = imm[5:0];
        in_last  = last;
        chk("beat_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (m_addr >= TOP) begin
            m_code = 2;
            ok     = 1'b0;
            chk("ovf_we", imem_we, 0);
            chk("ovf_err", err, 1);
            chk("ovf_code", err_code, 2);
            chk("ovf_ready", in_ready, 0);
            chk("ovf_count", count, m_count);
        end else if (!legal) begin
            m_code = 1;
            ok     = 1'b0;
            chk("ill_we", imem_we, 0);
            chk("ill_err", err, 1);
            chk("ill_code", err_code, 1);
            chk("ill_eaddr", err_addr, m_addr);
            chk("ill_ready", in_ready, 0);
        end else begin
            ok = 1'b1;
            chk("wr_we", imem_we, 1);
            chk("wr_addr", imem_addr, m_addr);
            chk("wr_data", imem_wdata, word);
            m_addr++;
            m_count++;
            chk("wr_count", count, m_count);
            if (last) begin
                chk("last_busy", busy, 1);
                chk("last_ready", in_ready, 0);
                chk("last_done", done, 0);
            end
        end
    endtask

    task automatic finish_session();
        step();
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        chk("fin_we", imem_we, 0);
        chk("fin_count", count, m_count);
        step();
        chk("fin_done_off", done, 0);
        chk("fin_idle_ready", in_ready, 0);
    endtask

    // Error must hold, with no writes and no acceptance, while beats keep arriving
    task automatic err_hold();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_ready", in_ready, 0);
            chk("hold_we", imem_we, 0);
            chk("hold_err", err, 1);
            chk("hold_code", err_code, m_code);
            chk("hold_busy", busy, 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int op, rd, rs, imm, w, n, base;
        bit lg, want_legal;

        // Reset state
        #12;
        chk_reset_vals("rst");
        Reset = 1'b1;
        step();
        chk("post_rst_ready", in_ready, 0);

        // MOV at base 0x10
        do_start(8'h10);
        do_beat(0, 3, 4, 0, 1'b0, ok);
        chk("mov_word", imem_wdata, 9'h034);
        do_beat(1, 0, 0, 1, 1'b1, ok);
        finish_session();

        // Back-to-back ADD then B, done pulse and final count
        do_start(8'h30);
        do_beat(8, 1, 0, 0, 1'b0, ok);
        chk("add_word", imem_wdata, 9'h1C1);
        do_beat(1, 0, 0, 5, 1'b1, ok);
        chk("b_word", imem_wdata, 9'h105);
        finish_session();
        chk("b2b_count", count, 2);

        // Illegal LI at 0x12
        do_start(8'h12);
        do_beat(2, 0, 0, 4, 1'b0, ok);
        chk("li_eaddr", err_addr, 8'h12);
        err_hold();

        // Overflow at top of memory
        do_start(8'hFF);
        do_beat(0, 1, 2, 0, 1'b0, ok);
        chk("top_addr", imem_addr, 8'hFF);
        do_beat(0, 1, 2, 0, 1'b1, ok);
        err_hold();

        // SBF legal and illegal flag codes
        do_start(8'h20);
        do_beat(7, 0, 0, 3, 1'b0, ok);
        chk("sbf_word", imem_wdata, 9'h1DB);
        do_beat(7, 0, 0, 2, 1'b0, ok);
        chk("sbf_eaddr", err_addr, 8'h21);
        err_hold();

        // Reset in the cycle after an accepted beat
        do_start(8'h40);
        do_beat(8, 3, 0, 0, 1'b0, ok);
        #2;
        Reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        #2;
        Reset = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midrst_ready", in_ready, 0);
            chk("midrst_we", imem_we, 0);
            chk("midrst_busy", busy, 0);
        end
        in_valid = 1'b0;

        // Randomized sessions with gaps, ignored Starts, illegal ops and overflow
        for (int s = 0; s < 30; s++) begin
            base = ($urandom_range(0, 3) == 0) ? $urandom_range(TOP - 6, TOP - 1)
                                               : $urandom_range(0, TOP - 1);
            do_start(base);
            n  = $urandom_range(1, 8);
            ok = 1'b1;
            for (int i = 0; i < n && ok; i++) begin
                idle($urandom_range(0, 2), ($urandom_range(0, 3) == 0));
                want_legal = ($urandom_range(0, 4) != 0);
                for (int t = 0; t < 50; t++) begin
                    op  = $urandom_range(0, 15);
                    rd  = $urandom_range(0, 15);
                    rs  = $urandom_range(0, 15);
                    imm = $urandom_range(0, 63);
                    ref_enc(op, rd, rs, imm, w, lg);
                    if (lg || !want_legal) break;
                end
                do_beat(op, rd, rs, imm, (i == n - 1), ok);
            end
            if (ok) finish_session();
            else    err_hold();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
